// File: rtl/ppg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppg_bank_pkg
//  Description : Shared definitions for the multi-channel pulse generator:
//                FSM state encoding used by the ppg_bank top level.
//  Revision    : 1.0  initial release
// ============================================================================
package ppg_bank_pkg;

    // Two-state frame sequencer: waiting for a trigger, or generating frames.
    typedef enum logic [0:0] {
        PPG_IDLE = 1'b0,
        PPG_RUN  = 1'b1
    } ppg_state_t;

endpackage : ppg_bank_pkg
`default_nettype wire

// File: rtl/ppg_bank_chan.sv
`default_nettype none
// ============================================================================
//  Module      : ppg_bank_chan
//  Description : One pulse-generator lane. Compares the shared frame counter
//                against this lane's lead/hold window and registers the
//                polarity-adjusted result.
//  Revision    : 1.0  initial release
// ============================================================================
module ppg_bank_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_fcnt,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_lead,
    input  logic [WIDTH-1:0] i_hold,
    input  logic             i_pol,
    input  logic             i_en,
    output logic             o_q
);

    // One extra bit so fcnt - lead can never wrap into a false "inside" result.
    logic [WIDTH:0] w_fcnt_x;
    logic [WIDTH:0] w_lead_x;
    logic [WIDTH:0] w_hold_x;
    logic [WIDTH:0] w_ofs;
    logic           w_act;
    logic           r_q;

    assign w_fcnt_x = {1'b0, i_fcnt};
    assign w_lead_x = {1'b0, i_lead};
    assign w_hold_x = {1'b0, i_hold};
    assign w_ofs    = w_fcnt_x - w_lead_x;
    assign w_act    = i_run & i_en & (w_fcnt_x >= w_lead_x) & (w_ofs < w_hold_x);

    // Register the window result; outside RUN the lane sits at its idle level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_act ^ i_pol;
        end
    end

    assign o_q = r_q;

endmodule : ppg_bank_chan
`default_nettype wire

// File: rtl/ppg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ppg_bank
//  Description : Multi-channel programmable pulse generator. A shared frame
//                counter is repeated n_rep times (or forever when n_rep==0)
//                after a trigger; each lane produces its own lead/hold pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module ppg_bank #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int RPT_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               trig,
    input  logic               abort,
    input  logic [WIDTH-1:0]   t_period,
    input  logic [RPT_W-1:0]   n_rep,
    input  logic [NCH*WIDTH-1:0] t_lead,
    input  logic [NCH*WIDTH-1:0] t_hold,
    input  logic [NCH-1:0]     pol,
    input  logic [NCH-1:0]     ch_en,
    output logic [NCH-1:0]     q,
    output logic               busy,
    output logic               done,
    output logic               err
);

    import ppg_bank_pkg::*;

    localparam logic [WIDTH-1:0] c_FCNT_ONE = WIDTH'(1);
    localparam logic [RPT_W-1:0] c_RCNT_ONE = RPT_W'(1);

    ppg_state_t           r_state;
    ppg_state_t           w_state_nxt;
    logic [WIDTH-1:0]     r_fcnt;
    logic [WIDTH-1:0]     w_fcnt_nxt;
    logic [RPT_W-1:0]     r_rcnt;
    logic [RPT_W-1:0]     w_rcnt_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 w_load;
    logic                 w_last_cyc;
    logic                 w_last_frm;
    logic                 w_run;

    // Configuration captured at trigger time; live inputs are ignored in RUN.
    logic [WIDTH-1:0]     r_period;
    logic [RPT_W-1:0]     r_nrep;
    logic [NCH*WIDTH-1:0] r_lead;
    logic [NCH*WIDTH-1:0] r_hold;
    logic [NCH-1:0]       r_pol;
    logic [NCH-1:0]       r_en;

    assign w_last_cyc = (r_fcnt == (r_period - c_FCNT_ONE));
    assign w_last_frm = (r_nrep != '0) && (r_rcnt == (r_nrep - c_RCNT_ONE));

    // Next-state logic: trigger acceptance, frame counting, repeat termination.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_rcnt_nxt  = r_rcnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            PPG_IDLE: begin
                w_fcnt_nxt = '0;
                w_rcnt_nxt = '0;
                // Abort has priority over a same-cycle trigger: no start, no error.
                if (trig && !abort) begin
                    if (t_period != '0) begin
                        w_state_nxt = PPG_RUN;
                        w_load      = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            PPG_RUN: begin
                if (abort) begin
                    w_state_nxt = PPG_IDLE;
                    w_fcnt_nxt  = '0;
                    w_rcnt_nxt  = '0;
                end else if (w_last_cyc) begin
                    w_fcnt_nxt = '0;
                    if (w_last_frm) begin
                        w_state_nxt = PPG_IDLE;
                        w_rcnt_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_rcnt_nxt = r_rcnt + c_RCNT_ONE;
                    end
                end else begin
                    w_fcnt_nxt = r_fcnt + c_FCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = PPG_IDLE;
            end
        endcase
    end

    // State, counters and single-cycle status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= PPG_IDLE;
            r_fcnt  <= '0;
            r_rcnt  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Shadow configuration loaded only on an accepted trigger.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_period <= '0;
            r_nrep   <= '0;
            r_lead   <= '0;
            r_hold   <= '0;
            r_pol    <= '0;
            r_en     <= '0;
        end else if (w_load) begin
            r_period <= t_period;
            r_nrep   <= n_rep;
            r_lead   <= t_lead;
            r_hold   <= t_hold;
            r_pol    <= pol;
            r_en     <= ch_en;
        end
    end

    // Abort drops the lanes to idle on the same edge that leaves RUN.
    assign w_run = (r_state == PPG_RUN) && !abort;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            ppg_bank_chan #(
                .WIDTH (WIDTH)
            ) u_chan (
                .clk    (clk),
                .rstn   (rstn),
                .i_fcnt (r_fcnt),
                .i_run  (w_run),
                .i_lead (r_lead[gi*WIDTH +: WIDTH]),
                .i_hold (r_hold[gi*WIDTH +: WIDTH]),
                .i_pol  (r_pol[gi]),
                .i_en   (r_en[gi]),
                .o_q    (q[gi])
            );
        end
    endgenerate

    assign busy = (r_state == PPG_RUN);
    assign done = r_done;
    assign err  = r_err;

endmodule : ppg_bank
`default_nettype wire
